// File: rtl/imem_rd_if.sv
// Instruction-memory read handshake plus preload/write port, shared by the
// fetch stage (master) and the instruction store (slave).
interface imem_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ready;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output mem_rd_addr, mem_rd_enable, load_en, load_addr, load_data,
    input  mem_rd_data, mem_rd_ready
  );

  modport slave (
    input  mem_rd_addr, mem_rd_enable, load_en, load_addr, load_data,
    output mem_rd_data, mem_rd_ready
  );
endinterface

// File: rtl/imem_rd_responder.sv
// Word-organised instruction store answering one read at a time after a
// programmable latency; aborts on dropped/retargeted requests.
module imem_rd_responder #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 2,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  logic      clk,
  input  logic      reset,
  imem_rd_if.slave  bus,
  output logic      busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx;
  logic              rd_oor;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_oor;
  logic [DATA_W-1:0] sample_word;

  // In IDLE the sample (LATENCY=1 case) uses the live address; otherwise the latched one.
  always_comb begin
    if (state_q == S_IDLE) begin
      rd_idx = bus.mem_rd_addr[IDX_W+1:2];
      rd_oor = |bus.mem_rd_addr[ADDR_W-1:IDX_W+2];
    end else begin
      rd_idx = req_addr_q[IDX_W+1:2];
      rd_oor = |req_addr_q[ADDR_W-1:IDX_W+2];
    end
    ld_idx = bus.load_addr[IDX_W+1:2];
    ld_oor = |bus.load_addr[ADDR_W-1:IDX_W+2];
  end

  // Write-first: a load landing on the sampling edge must be returned.
  always_comb begin
    if (rd_oor)
      sample_word = OOR_DATA;
    else if (bus.load_en && !ld_oor && (ld_idx == rd_idx))
      sample_word = bus.load_data;
    else
      sample_word = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (bus.load_en && !ld_oor)
      mem[ld_idx] <= bus.load_data;
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_rd_enable) begin
          req_addr_d = bus.mem_rd_addr;
          if (LATENCY == 1) begin
            state_d = S_READY;
            data_d  = sample_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_RELOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_rd_enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.mem_rd_addr != req_addr_q) begin
          req_addr_d = bus.mem_rd_addr;
          cnt_d      = CNT_RELOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_READY;
          cnt_d   = '0;
          data_d  = sample_word;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

  assign bus.mem_rd_data  = data_q;
  assign bus.mem_rd_ready = (state_q == S_READY);
  assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_imem_rd_responder.sv
// Directed bench for imem_rd_responder (DEPTH=1024, LATENCY=2, OOR_DATA=0).
module tb_imem_rd_responder;
  logic clk;
  logic reset;
  logic busy;
  int   errors;
  int   checks;

  imem_rd_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_rd_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LATENCY(2), .OOR_DATA(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", bus.mem_rd_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (bus.mem_rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", bus.mem_rd_data);
    end
    reset = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_basic();
    load_word(32'h0, 32'h00500093);
    load_word(32'h4, 32'h00100113);
    bus.mem_rd_addr   = 32'h0;
    bus.mem_rd_enable = 1'b1;
    step();  // accepting edge
    checks++;
    if (bus.mem_rd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_wait: ready=%b busy=%b want ready=0 busy=1", bus.mem_rd_ready, busy);
    end
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'h00500093) begin
      errors++; $display("FAIL basic_ready: ready=%b data=%h want ready=1 data=00500093", bus.mem_rd_ready, bus.mem_rd_data);
    end
    step();  // handshake edge
    bus.mem_rd_enable = 1'b0;
    checks++;
    if (bus.mem_rd_ready !== 1'b0) begin
      errors++; $display("FAIL basic_drop: ready=%b want 0", bus.mem_rd_ready);
    end
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: ready=%b busy=%b want 0 0", bus.mem_rd_ready, busy);
    end
    $display("basic: addr=0 data=%h", bus.mem_rd_data);
  endtask

  task automatic test_back_to_back();
    logic [8:0] pattern;
    int hs;
    pattern = 9'b010_010_010;  // bit 8 = after first edge
    hs = 0;
    bus.mem_rd_addr   = 32'h4;
    bus.mem_rd_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (bus.mem_rd_ready !== pattern[8-i]) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.mem_rd_ready, pattern[8-i]);
      end
      if (bus.mem_rd_ready === 1'b1) begin
        hs++;
        checks++;
        if (bus.mem_rd_data !== 32'h00100113) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want 00100113", i, bus.mem_rd_data);
        end
      end
    end
    bus.mem_rd_enable = 1'b0;
    checks++;
    if (hs != 3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", hs);
    end
    step();
    step();
    $display("back_to_back: %0d handshakes", hs);
  endtask

  task automatic test_reset_mid();
    bus.mem_rd_addr   = 32'h0;
    bus.mem_rd_enable = 1'b1;
    step();  // accepted, now in WAIT
    reset = 1'b1;
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b0 || busy !== 1'b0 || bus.mem_rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ready=%b busy=%b data=%h want 0 0 00000000", bus.mem_rd_ready, busy, bus.mem_rd_data);
    end
    reset = 1'b0;
    bus.mem_rd_enable = 1'b0;
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: ready=%b busy=%b want 0 0", bus.mem_rd_ready, busy);
    end
    $display("reset_mid: request discarded");
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    bus.mem_rd_addr   = 32'h0;
    bus.mem_rd_enable = 1'b1;
    step();
    bus.mem_rd_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.mem_rd_ready === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_abort: ready_seen=%0d busy=%b want 0 0", seen, busy);
    end
    bus.mem_rd_addr   = 32'h4;
    bus.mem_rd_enable = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'h00100113) begin
      errors++; $display("FAIL flush_rereq: ready=%b data=%h want 1 00100113", bus.mem_rd_ready, bus.mem_rd_data);
    end
    step();
    bus.mem_rd_enable = 1'b0;
    step();
    $display("flush: rerequest data=%h", bus.mem_rd_data);
  endtask

  task automatic test_retarget();
    int resp;
    resp = 0;
    bus.mem_rd_addr   = 32'h0;
    bus.mem_rd_enable = 1'b1;
    step();
    bus.mem_rd_addr = 32'h4;
    step();  // retarget edge: counter reloads
    checks++;
    if (bus.mem_rd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL retarget_wait: ready=%b busy=%b want 0 1", bus.mem_rd_ready, busy);
    end
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'h00100113) begin
      errors++; $display("FAIL retarget_data: ready=%b data=%h want 1 00100113", bus.mem_rd_ready, bus.mem_rd_data);
    end
    if (bus.mem_rd_ready === 1'b1) resp++;
    step();
    bus.mem_rd_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.mem_rd_ready === 1'b1) resp++;
    end
    checks++;
    if (resp != 1) begin
      errors++; $display("FAIL retarget_count: got %0d want 1", resp);
    end
    $display("retarget: responses=%0d", resp);
  endtask

  task automatic test_oor();
    bus.mem_rd_addr   = 32'h0000_1000;
    bus.mem_rd_enable = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'h0) begin
      errors++; $display("FAIL oor_data: ready=%b data=%h want 1 00000000", bus.mem_rd_ready, bus.mem_rd_data);
    end
    step();
    bus.mem_rd_enable = 1'b0;
    step();
    $display("oor: data=%h", bus.mem_rd_data);
  endtask

  task automatic test_collision();
    load_word(32'h8, 32'h1111_1111);
    bus.mem_rd_addr   = 32'h8;
    bus.mem_rd_enable = 1'b1;
    step();  // accepted
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h8;
    bus.load_data = 32'hDEADBEEF;
    step();  // edge entering READY shares the write
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL collision_wf: ready=%b data=%h want 1 deadbeef", bus.mem_rd_ready, bus.mem_rd_data);
    end
    bus.load_data     = 32'h0;
    bus.mem_rd_enable = 1'b0;
    step();
    bus.load_en = 1'b0;
    checks++;
    if (bus.mem_rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL collision_hold: data=%h want deadbeef", bus.mem_rd_data);
    end
    bus.mem_rd_enable = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_rd_ready !== 1'b1 || bus.mem_rd_data !== 32'h0) begin
      errors++; $display("FAIL collision_reread: ready=%b data=%h want 1 00000000", bus.mem_rd_ready, bus.mem_rd_data);
    end
    step();
    bus.mem_rd_enable = 1'b0;
    step();
    $display("collision: write-first and hold verified");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.mem_rd_addr   = '0;
    bus.mem_rd_enable = 1'b0;
    bus.load_en       = 1'b0;
    bus.load_addr     = '0;
    bus.load_data     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    test_retarget();
    test_oor();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
